// File: rtl/can_rx_bit_sampler_if.sv
// Bus-side signals of the CAN receive bit sampler.
// The master side is the frame logic (it drives the raw line and the
// destuff enable and consumes the strobes); the slave side is the sampler.
interface can_rx_bit_sampler_if;
  logic can_rx;
  logic destuff_en;
  logic bit_valid;
  logic bit_value;
  logic sof;
  logic stuff_error;
  logic bus_idle;

  modport master (
    output can_rx,
    output destuff_en,
    input  bit_valid,
    input  bit_value,
    input  sof,
    input  stuff_error,
    input  bus_idle
  );

  modport slave (
    input  can_rx,
    input  destuff_en,
    output bit_valid,
    output bit_value,
    output sof,
    output stuff_error,
    output bus_idle
  );
endinterface

// File: rtl/can_rx_bit_sampler.sv
// CAN receive bit sampler: synchronises the raw line, locks bit timing
// (hard sync on SOF, resync on recessive-to-dominant edges), takes a
// 3-sample majority at the sample point, removes stuff bits and reports
// stuff violations and bus idle.
module can_rx_bit_sampler #(
  parameter int CLKS_PER_BIT = 16,
  parameter int SAMPLE_POINT = 11,
  parameter int IDLE_BITS    = 11
) (
  input logic                  clk,
  input logic                  reset,
  can_rx_bit_sampler_if.slave  bus
);

  localparam int TQ_W  = $clog2(CLKS_PER_BIT);
  localparam int REC_W = $clog2(IDLE_BITS + 1);

  localparam logic [TQ_W-1:0]  TQ_SAMPLE = TQ_W'(SAMPLE_POINT);
  localparam logic [TQ_W-1:0]  TQ_LAST   = TQ_W'(CLKS_PER_BIT - 1);
  localparam logic [REC_W-1:0] REC_IDLE  = REC_W'(IDLE_BITS);
  localparam logic [2:0]       RUN_MAX   = 3'd5;

  typedef enum logic [1:0] {
    WAIT_IDLE,
    IDLE,
    SOF_CHK,
    RUN
  } state_t;

  logic             sync1_q, sync1_d;
  logic             rx_s_q, rx_s_d;
  logic             rx_prev_q, rx_prev_d;
  logic [2:0]       maj_q, maj_d;
  logic [TQ_W-1:0]  tq_cnt_q, tq_cnt_d;
  state_t           state_q, state_d;
  logic [REC_W-1:0] rec_cnt_q, rec_cnt_d;
  logic [2:0]       run_len_q, run_len_d;
  logic             last_bit_q, last_bit_d;
  logic             bit_valid_q, bit_valid_d;
  logic             bit_value_q, bit_value_d;
  logic             sof_q, sof_d;
  logic             stuff_error_q, stuff_error_d;
  logic             bus_idle_q, bus_idle_d;

  logic             falling_edge;
  logic             sample_pt;
  logic             sample_bit;
  logic [REC_W-1:0] rec_after;
  logic [2:0]       run_after;

  // Input path: two-flop synchroniser, edge history and majority window.
  always_comb begin
    sync1_d   = bus.can_rx;
    rx_s_d    = sync1_q;
    rx_prev_d = rx_s_q;
    maj_d     = {maj_q[1:0], rx_s_q};
  end

  // Derived per-cycle terms: edge detect, sample point, voted bit and the
  // counters as they would look if the current sample were accepted.
  always_comb begin
    falling_edge = rx_prev_q & ~rx_s_q;
    sample_pt    = (tq_cnt_q == TQ_SAMPLE);
    sample_bit   = (maj_q[0] & maj_q[1]) | (maj_q[0] & maj_q[2]) | (maj_q[1] & maj_q[2]);
    if (!sample_bit) begin
      rec_after = '0;
    end else if (rec_cnt_q == REC_IDLE) begin
      rec_after = REC_IDLE;
    end else begin
      rec_after = rec_cnt_q + REC_W'(1);
    end
    if (sample_bit != last_bit_q) begin
      run_after = 3'd1;
    end else if (run_len_q == RUN_MAX) begin
      run_after = RUN_MAX;
    end else begin
      run_after = run_len_q + 3'd1;
    end
  end

  // Bit-timing and destuffing FSM: next state, counters and output strobes.
  always_comb begin
    state_d       = state_q;
    tq_cnt_d      = (tq_cnt_q == TQ_LAST) ? '0 : tq_cnt_q + TQ_W'(1);
    rec_cnt_d     = rec_cnt_q;
    run_len_d     = run_len_q;
    last_bit_d    = last_bit_q;
    bit_valid_d   = 1'b0;
    bit_value_d   = bit_value_q;
    sof_d         = 1'b0;
    stuff_error_d = 1'b0;
    bus_idle_d    = bus_idle_q;

    case (state_q)
      WAIT_IDLE: begin
        if (sample_pt) begin
          rec_cnt_d = rec_after;
          if (rec_after == REC_IDLE) begin
            state_d    = IDLE;
            bus_idle_d = 1'b1;
          end
        end
      end

      IDLE: begin
        if (falling_edge) begin
          tq_cnt_d = '0;
          state_d  = SOF_CHK;
        end
      end

      SOF_CHK: begin
        if (sample_pt) begin
          if (!sample_bit) begin
            bit_valid_d = 1'b1;
            bit_value_d = 1'b0;
            sof_d       = 1'b1;
            last_bit_d  = 1'b0;
            run_len_d   = 3'd1;
            rec_cnt_d   = '0;
            bus_idle_d  = 1'b0;
            state_d     = RUN;
          end else begin
            state_d = IDLE;
          end
        end
      end

      RUN: begin
        if (falling_edge && last_bit_q) begin
          tq_cnt_d = '0;
        end
        if (sample_pt) begin
          if (bus.destuff_en && (run_len_q == RUN_MAX) && (sample_bit == last_bit_q)) begin
            stuff_error_d = 1'b1;
            rec_cnt_d     = '0;
            state_d       = WAIT_IDLE;
          end else begin
            if (bus.destuff_en && (run_len_q == RUN_MAX)) begin
              run_len_d = 3'd1;
            end else begin
              bit_valid_d = 1'b1;
              bit_value_d = sample_bit;
              run_len_d   = run_after;
            end
            last_bit_d = sample_bit;
            rec_cnt_d  = rec_after;
            if (rec_after == REC_IDLE) begin
              state_d    = IDLE;
              bus_idle_d = 1'b1;
            end
          end
        end
      end

      default: begin
        state_d = WAIT_IDLE;
      end
    endcase
  end

  // State register with synchronous reset; a reset mid-frame drops the frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q       <= 1'b1;
      rx_s_q        <= 1'b1;
      rx_prev_q     <= 1'b1;
      maj_q         <= 3'b111;
      tq_cnt_q      <= '0;
      state_q       <= WAIT_IDLE;
      rec_cnt_q     <= '0;
      run_len_q     <= '0;
      last_bit_q    <= 1'b1;
      bit_valid_q   <= 1'b0;
      bit_value_q   <= 1'b1;
      sof_q         <= 1'b0;
      stuff_error_q <= 1'b0;
      bus_idle_q    <= 1'b0;
    end else begin
      sync1_q       <= sync1_d;
      rx_s_q        <= rx_s_d;
      rx_prev_q     <= rx_prev_d;
      maj_q         <= maj_d;
      tq_cnt_q      <= tq_cnt_d;
      state_q       <= state_d;
      rec_cnt_q     <= rec_cnt_d;
      run_len_q     <= run_len_d;
      last_bit_q    <= last_bit_d;
      bit_valid_q   <= bit_valid_d;
      bit_value_q   <= bit_value_d;
      sof_q         <= sof_d;
      stuff_error_q <= stuff_error_d;
      bus_idle_q    <= bus_idle_d;
    end
  end

  assign bus.bit_valid   = bit_valid_q;
  assign bus.bit_value   = bit_value_q;
  assign bus.sof         = sof_q;
  assign bus.stuff_error = stuff_error_q;
  assign bus.bus_idle    = bus_idle_q;

endmodule
